// File: rtl/pipe_pkg.sv
// pipe_pkg: shared ctrl bit indices and occupancy/state encodings for pipeline stages
package pipe_pkg;
    localparam int CTRL_WB = 0;
    localparam int CTRL_MEM = 1;
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE = 2'd1;
    localparam logic [1:0] OCC_FULL = 2'd2;
    typedef enum logic [1:0] {
        S_EMPTY = OCC_EMPTY,
        S_ONE = OCC_ONE,
        S_FULL = OCC_FULL
    } state_e;
endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: concatenated-payload register with sync reset and load enable
module pipe_entry_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] data_q;
    always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else if (ld_i) data_q <= d_i;
    end
    assign q_o = data_q;
endmodule

// File: rtl/pipe_stage_skid_buff.sv
// pipe_stage_skid_buff: valid/ready pipeline stage with 2-entry skid, registered in_ready and flush-to-bubble
module pipe_stage_skid_buff
    import pipe_pkg::*;
#(
    parameter int PC_W = 32,
    parameter int DATA_W = 16,
    parameter int REG_W = 3,
    parameter int CTRL_W = 2,
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [REG_W-1:0]  in_rdst,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_rd1,
    input  logic [FLAG_W-1:0] in_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [PC_W-1:0]   out_pc,
    output logic [REG_W-1:0]  out_rdst,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_rd1,
    output logic [FLAG_W-1:0] out_flags,
    output logic [1:0]        occupancy
);
    localparam int W = CTRL_W + PC_W + REG_W + 2 * DATA_W + FLAG_W;
    state_e state_q, state_d;
    logic in_ready_q;
    logic main_ld, skid_ld, in_fire, out_fire;
    logic [W-1:0] in_data, main_d, main_q, skid_q;
    logic [CTRL_W-1:0] main_ctrl;
    assign in_data = {in_ctrl, in_pc, in_rdst, in_alu, in_rd1, in_flags};
    assign in_fire = in_valid & in_ready_q;
    assign out_fire = out_valid & out_ready;
    // When FULL the only possible MAIN load is the skid entry moving forward
    assign main_d = (state_q == S_FULL) ? skid_q : in_data;
    always_comb begin
        state_d = state_q;
        main_ld = 1'b0;
        skid_ld = 1'b0;
        if (flush) state_d = S_EMPTY;
        else begin
            case (state_q)
                S_EMPTY: begin
                    main_ld = in_fire;
                    state_d = in_fire ? S_ONE : S_EMPTY;
                end
                S_ONE: begin
                    main_ld = in_fire & out_fire;
                    skid_ld = in_fire & ~out_fire;
                    state_d = (in_fire & ~out_fire) ? S_FULL : ((out_fire & ~in_fire) ? S_EMPTY : S_ONE);
                end
                S_FULL: begin
                    main_ld = out_fire;
                    state_d = out_fire ? S_ONE : S_FULL;
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            in_ready_q <= (state_d != S_FULL);
        end
    end
    pipe_entry_reg #(.W(W)) u_main (.clk(clk), .rst(rst), .ld_i(main_ld), .d_i(main_d), .q_o(main_q));
    pipe_entry_reg #(.W(W)) u_skid (.clk(clk), .rst(rst), .ld_i(skid_ld), .d_i(in_data), .q_o(skid_q));
    assign {main_ctrl, out_pc, out_rdst, out_alu, out_rd1, out_flags} = main_q;
    assign out_valid = (state_q != S_EMPTY);
    assign out_ctrl = out_valid ? main_ctrl : '0;
    assign in_ready = in_ready_q;
    assign occupancy = state_q;
endmodule

// File: tb/tb_pipe_stage_skid_buff.sv
// tb_pipe_stage_skid_buff: directed plus random stimulus against a queue-based reference model
module tb_pipe_stage_skid_buff;
    localparam int W = 73;
    logic clk = 1'b0;
    logic rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0] in_ctrl = '0;
    logic [31:0] in_pc = '0;
    logic [2:0] in_rdst = '0;
    logic [15:0] in_alu = '0, in_rd1 = '0;
    logic [3:0] in_flags = '0;
    logic in_ready, out_valid;
    logic [1:0] out_ctrl, occupancy;
    logic [31:0] out_pc;
    logic [2:0] out_rdst;
    logic [15:0] out_alu, out_rd1;
    logic [3:0] out_flags;
    int total = 0, bad = 0;
    logic [W-1:0] mq[$];
    logic [W-1:0] m_last = '0;
    logic m_rdy = 1'b0;
    always #5 clk = ~clk;
    pipe_stage_skid_buff dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_pc(in_pc), .in_rdst(in_rdst), .in_alu(in_alu), .in_rd1(in_rd1),
        .in_flags(in_flags), .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_pc(out_pc), .out_rdst(out_rdst), .out_alu(out_alu), .out_rd1(out_rd1),
        .out_flags(out_flags), .occupancy(occupancy)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic check_all();
        logic ev;
        ev = mq.size() > 0;
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("in_ready", 32'(in_ready), 32'(m_rdy));
        chk("occupancy", 32'(occupancy), 32'(mq.size()));
        chk("out_ctrl", 32'(out_ctrl), ev ? 32'(m_last[72:71]) : 32'd0);
        chk("out_pc", out_pc, m_last[70:39]);
        chk("out_rdst", 32'(out_rdst), 32'(m_last[38:36]));
        chk("out_alu", 32'(out_alu), 32'(m_last[35:20]));
        chk("out_rd1", 32'(out_rd1), 32'(m_last[19:4]));
        chk("out_flags", 32'(out_flags), 32'(m_last[3:0]));
    endtask
    // One clock: drive inputs, advance the reference queue with the same handshake rules, compare.
    task automatic cyc(input logic r, input logic fl, input logic iv, input logic [31:0] pc,
                       input logic [15:0] alu, input logic [1:0] ctrl, input logic ordy);
        logic [W-1:0] p;
        logic fin, fout;
        p = {ctrl, pc, 3'($urandom), alu, 16'($urandom), 4'($urandom)};
        {in_ctrl, in_pc, in_rdst, in_alu, in_rd1, in_flags} = p;
        rst = r;
        flush = fl;
        in_valid = iv;
        out_ready = ordy;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_rdy = 1'b0;
            m_last = '0;
        end else begin
            fin = iv && m_rdy;
            fout = (mq.size() > 0) && ordy;
            if (fl) mq.delete();
            else begin
                if (fout) void'(mq.pop_front());
                if (fin) mq.push_back(p);
            end
            if (mq.size() > 0) m_last = mq[0];
            m_rdy = mq.size() < 2;
        end
        #1;
        check_all();
    endtask
    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 32'h100, 16'h1234, 2'b01, 1);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        cyc(0, 0, 1, 32'h100, 16'h1234, 2'b01, 1);
        chk("ready_after_rst", 32'(in_ready), 32'd1);
        cyc(0, 0, 1, 32'h100, 16'h1234, 2'b01, 1);
        chk("first_pc", out_pc, 32'h100);
        chk("first_alu", 32'(out_alu), 32'h1234);
        chk("first_occ", 32'(occupancy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 32'(i), 16'(i * 3), 2'b11, 1);
            chk("stream_pc", out_pc, 32'(i));
        end
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 32'hA, 16'h0A, 2'b01, 0);
        cyc(0, 0, 1, 32'hB, 16'h0B, 2'b10, 0);
        chk("bp_occ", 32'(occupancy), 32'd2);
        chk("bp_ready", 32'(in_ready), 32'd0);
        chk("bp_pc", out_pc, 32'hA);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("bp_hold", out_pc, 32'hA);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("bp_drain_b", out_pc, 32'hB);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 32'h20, 16'h20, 2'b11, 0);
        cyc(0, 0, 1, 32'h21, 16'h21, 2'b11, 0);
        cyc(0, 1, 1, 32'hC, 16'h0C, 2'b11, 0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ctrl", 32'(out_ctrl), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        cyc(0, 0, 1, 32'hC, 16'h0C, 2'b11, 1);
        chk("after_flush_pc", out_pc, 32'hC);
        cyc(0, 1, 1, 32'hD, 16'h0D, 2'b11, 1);
        chk("flush_drop_valid", 32'(out_valid), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("flush_drop_still", 32'(out_valid), 32'd0);
        cyc(0, 0, 1, 32'h30, 16'h30, 2'b11, 0);
        cyc(0, 0, 1, 32'h31, 16'h31, 2'b11, 0);
        chk("pre_rst_occ", 32'(occupancy), 32'd2);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("mid_rst_pc", out_pc, 32'd0);
        chk("mid_rst_alu", 32'(out_alu), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("mid_rst_gone", 32'(out_valid), 32'd0);
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, 1'($urandom),
                $urandom, 16'($urandom), 2'($urandom), $urandom_range(0, 2) != 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
